// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (I) and MEM-stage (D)
// ports through a req/gnt/rvalid handshake, data side first because it is the older instruction.
// Optional build macro ARB_PERF_EN adds saturating stall-cycle counters perf_stall_f/perf_stall_m.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rvalid,
    output logic            stall_f,
`ifdef ARB_PERF_EN
    output logic            stall_m,
    output logic [31:0]     perf_stall_f,
    output logic [31:0]     perf_stall_m
`else
    output logic            stall_m
`endif
);

    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t stateNext;
    logic   ownerD;
    logic   loadD;
    logic   loadI;
    logic   memReqNext;
    logic   iValidNext;
    logic   dValidNext;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: one access in flight, DONE always falls back to IDLE without sampling requests
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (d_req || i_req) stateNext = ISSUE;
            ISSUE:   if (mem_gnt)        stateNext = WAIT;
            WAIT:    if (mem_rvalid)     stateNext = DONE;
            DONE:                        stateNext = IDLE;
            default:                     stateNext = IDLE;
        endcase
    end

    // Output decode: next values for the registered memory-side and completion outputs
    always_comb begin
        loadD      = 1'b0;
        loadI      = 1'b0;
        memReqNext = 1'b0;
        iValidNext = 1'b0;
        dValidNext = 1'b0;
        if (state == IDLE) begin
            loadD = d_req;
            loadI = ~d_req & i_req;
        end
        if (state == WAIT && mem_rvalid) begin
            iValidNext = ~ownerD;
            dValidNext = ownerD;
        end
        memReqNext = (stateNext == ISSUE);
    end

    // Request latch, owner tracking, response capture and valid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            ownerD    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            mem_req <= memReqNext;
            i_valid <= iValidNext;
            d_valid <= dValidNext;
            if (loadD) begin
                ownerD    <= 1'b1;
                mem_we    <= d_we;
                mem_be    <= d_be;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (loadI) begin
                ownerD    <= 1'b0;
                mem_we    <= 1'b0;
                mem_be    <= {BW{1'b1}};
                mem_addr  <= i_addr;
            end
            if (iValidNext) i_rdata <= mem_rdata;
            if (dValidNext) d_rdata <= mem_rdata;
        end
    end

    // Pipeline stalls: held until the owning access completes
    assign stall_f = i_req & ~i_valid;
    assign stall_m = d_req & ~d_valid;

`ifdef ARB_PERF_EN
    // Saturating stall-cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_f <= '0;
            perf_stall_m <= '0;
        end else begin
            if (stall_f && perf_stall_f != 32'hFFFF_FFFF) perf_stall_f <= perf_stall_f + 32'd1;
            if (stall_m && perf_stall_m != 32'hFFFF_FFFF) perf_stall_m <= perf_stall_m + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/priority/reset scenarios plus a randomized
// two-requester phase against a reactive memory model, checked through per-port scoreboards.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        stall_f;
    logic        stall_m;
`ifdef ARB_PERF_EN
    logic [31:0] perf_stall_f;
    logic [31:0] perf_stall_m;
`endif

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .stall_f(stall_f),
`ifdef ARB_PERF_EN
        .stall_m(stall_m), .perf_stall_f(perf_stall_f), .perf_stall_m(perf_stall_m)
`else
        .stall_m(stall_m)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } issue_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] iExpQ[$];
    logic [31:0] dExpQ[$];
    issue_t      issueLog[$];
    int          issueCount = 0;
    int          lastIssueCycles = 0;
    int          gntDelay = 0;
    int          rvDelay = 0;
    bit          randTiming = 0;
    logic [31:0] memArr[logic [31:0]];
    logic [31:0] refArr[logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-on image of the memory: any word not yet stored to
    function automatic logic [31:0] initWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refArr.exists(a) ? refArr[a] : initWord(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        memArr[a] = v;
        refArr[a] = v;
    endtask

    // Memory model: grants after a delay, answers after a further delay; writes return the merged word
    initial begin
        bit          inIssue;
        bit          pending;
        int          gCnt;
        int          rCnt;
        int          cycs;
        issue_t      snap;
        issue_t      cur;
        logic [31:0] resp;
        logic [31:0] word;
        inIssue = 0; pending = 0; gCnt = 0; rCnt = 0; cycs = 0; resp = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            cur = '{mem_addr, mem_we, mem_be, mem_wdata};
            if (pending) begin
                if (mem_req) check("no_mem_req_while_waiting", {63'd0, mem_req}, 64'd0);
                if (rCnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = resp;
                    pending = 0;
                end else begin
                    rCnt--;
                end
            end else if (mem_req) begin
                if (!inIssue) begin
                    inIssue = 1;
                    snap = cur;
                    cycs = 0;
                    gCnt = randTiming ? int'($urandom_range(0, 3)) : gntDelay;
                    issueLog.push_back(cur);
                    issueCount++;
                end else begin
                    check("mem_addr_stable", {32'd0, cur.addr}, {32'd0, snap.addr});
                    check("mem_ctl_stable", {27'd0, cur.we, cur.be, cur.wdata},
                          {27'd0, snap.we, snap.be, snap.wdata});
                end
                cycs++;
                if (gCnt == 0) begin
                    mem_gnt = 1'b1;
                    inIssue = 0;
                    pending = 1;
                    rCnt = randTiming ? int'($urandom_range(0, 3)) : rvDelay;
                    lastIssueCycles = cycs;
                    word = memArr.exists(cur.addr) ? memArr[cur.addr] : initWord(cur.addr);
                    if (cur.we) begin
                        word = mergeBytes(word, cur.wdata, cur.be);
                        memArr[cur.addr] = word;
                    end
                    resp = word;
                end else begin
                    gCnt--;
                end
            end
        end
    end

    // Monitor: pops each port's scoreboard on its completion pulse and checks the stall outputs
    initial begin
        forever begin
            @(negedge clk);
            if (reset) continue;
            check("stall_f", {63'd0, stall_f}, {63'd0, i_req & ~i_valid});
            check("stall_m", {63'd0, stall_m}, {63'd0, d_req & ~d_valid});
            if (i_valid && d_valid) check("single_valid", 64'd1, 64'd0);
            if (i_valid || d_valid) check("done_no_mem_req", {63'd0, mem_req}, 64'd0);
            if (i_valid) begin
                if (iExpQ.size() == 0) check("unexpected_i_valid", 64'd1, 64'd0);
                else check("i_rdata", {32'd0, i_rdata}, {32'd0, iExpQ.pop_front()});
            end
            if (d_valid) begin
                if (dExpQ.size() == 0) check("unexpected_d_valid", 64'd1, 64'd0);
                else check("d_rdata", {32'd0, d_rdata}, {32'd0, dExpQ.pop_front()});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following i_valid
    task automatic doFetch(input logic [31:0] a, output int lat);
        int start;
        bit seen;
        i_req = 1'b1;
        i_addr = a;
        iExpQ.push_back(refRead(a));
        start = cyc;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (i_valid) seen = 1;
        end
        lat = cyc - start;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: got no i_valid expected completion for addr %0h", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic doData(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
        int          start;
        bit          seen;
        logic [31:0] exp;
        d_req = 1'b1;
        d_we = we;
        d_be = be;
        d_addr = a;
        d_wdata = wd;
        exp = we ? mergeBytes(refRead(a), wd, be) : refRead(a);
        if (we) refArr[a] = exp;
        dExpQ.push_back(exp);
        start = cyc;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (d_valid) seen = 1;
        end
        lat = cyc - start;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL data_timeout: got no d_valid expected completion for addr %0h", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int il;
        int dl;
        int l1;
        int n0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we_be", {59'd0, mem_we, mem_be}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_valids", {62'd0, i_valid, d_valid}, 64'd0);
        check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        reset = 1'b0;

        // Single fetch, immediate grant and response
        preload(32'h100, 32'h0050_0093);
        doFetch(32'h100, il);
        i_req = 1'b0;
        check("s1_latency", il, 3);
        check("s1_i_rdata_hold", {32'd0, i_rdata}, 64'h0050_0093);

        // Simultaneous fetch and load: data side first
        doReset();
        n0 = issueLog.size();
        fork
            begin doData(1'b0, 4'hF, 32'h200, 32'h0, dl); d_req = 1'b0; end
            begin doFetch(32'h100, il); i_req = 1'b0; end
        join
        check("s2_d_latency", dl, 3);
        check("s2_i_latency", il, 7);
        check("s2_first_addr", {32'd0, issueLog[n0].addr}, 64'h200);
        check("s2_second_addr", {32'd0, issueLog[n0+1].addr}, 64'h100);
`ifdef ARB_PERF_EN
        check("s2_perf_stall_m", {32'd0, perf_stall_m}, 64'd3);
        check("s2_perf_stall_f", {32'd0, perf_stall_f}, 64'd7);
`endif

        // Store with a grant held back three cycles
        gntDelay = 3;
        n0 = issueLog.size();
        doData(1'b1, 4'b0011, 32'h300, 32'hDEAD_BEEF, dl);
        d_req = 1'b0;
        gntDelay = 0;
        check("s3_issue_cycles", lastIssueCycles, 4);
        check("s3_d_latency", dl, 6);
        check("s3_mem_we_be", {59'd0, issueLog[n0].we, issueLog[n0].be}, 64'h13);
        check("s3_mem_wdata", {32'd0, issueLog[n0].wdata}, 64'hDEAD_BEEF);

        // Reset while waiting for the response; the late response must be ignored
        rvDelay = 3;
        i_req = 1'b1;
        i_addr = 32'h400;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rvDelay = 0;
        repeat (6) begin
            @(negedge clk);
            check("s4_no_valid", {62'd0, i_valid, d_valid}, 64'd0);
            check("s4_no_mem_req", {63'd0, mem_req}, 64'd0);
        end
        @(posedge clk); #1;
        doFetch(32'h404, il);
        i_req = 1'b0;
        check("s4_after_reset_latency", il, 3);

        // Back-to-back loads with d_req held across the completion
        n0 = issueCount;
        doData(1'b0, 4'hF, 32'h204, 32'h0, l1);
        doData(1'b0, 4'hF, 32'h208, 32'h0, dl);
        d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("s5_first_latency", l1, 3);
        check("s5_second_latency", dl, 3);
        check("s5_issue_count", issueCount - n0, 2);

        // Randomized traffic from both requesters
        randTiming = 1;
        fork
            begin
                int lat;
                int gap;
                for (int n = 0; n < 40; n++) begin
                    doFetch(32'h8000 + 32'(4 * $urandom_range(0, 63)), lat);
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        i_req = 1'b0;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                end
                i_req = 1'b0;
            end
            begin
                int lat;
                int gap;
                for (int n = 0; n < 40; n++) begin
                    doData(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           32'h1000 + 32'(4 * $urandom_range(0, 15)), $urandom, lat);
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        d_req = 1'b0;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                end
                d_req = 1'b0;
            end
        join
        randTiming = 0;
        repeat (10) @(posedge clk);
        #1;
        check("i_queue_drained", iExpQ.size(), 0);
        check("d_queue_drained", dExpQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
